// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the memory responder.
//   ADDR_W / DATA_W : bus widths (16-bit address, 8-bit data)
//   DEF_*           : default parameter values for mem_responder
//   mr_state_t      : responder FSM states
//   in_win()        : RAM window membership test
package mem_responder_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEF_BASE  = 16'h0000;
  localparam int                DEF_DEPTH = 256;
  localparam int                DEF_WAIT  = 2;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, ERR} mr_state_t;

  // Difference taken in 17 bits so an address below base shows up as a set
  // sign bit rather than wrapping into the window.
  function automatic logic in_win(input logic [ADDR_W-1:0] a,
                                  input logic [ADDR_W-1:0] base,
                                  input logic [31:0]       depth);
    logic [ADDR_W:0] diff;
    diff = {1'b0, a} - {1'b0, base};
    return !diff[ADDR_W] && ({15'b0, diff} < depth);
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: DEPTH x 8 single-port RAM.
//   clk : clock
//   we  : write enable, write at rising edge
//   a   : byte address (shared by read and write)
//   wd  : write data
//   rd  : asynchronous read data at a
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[a] <= wd;
  end

  assign rd = mem[a];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: bus-side responder serving byte / little-endian 16-bit
// reads and writes from a local RAM window, with WAIT wait states per beat.
//   clk, rst      : clock, synchronous active-low reset
//   abi, dbi      : request address, write data
//   req, we, wid  : request strobe, write select, two-byte select
//   dbo           : read data (held until the next read beat)
//   rdy, err      : beat-complete pulse, out-of-window pulse
//   busy          : transfer in progress
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE  = DEF_BASE,
  parameter int                DEPTH = DEF_DEPTH,
  parameter int                WAIT  = DEF_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] abi,
  input  logic [DATA_W-1:0] dbi,
  input  logic              req,
  input  logic              we,
  input  logic              wid,
  output logic [DATA_W-1:0] dbo,
  output logic              rdy,
  output logic              err,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mr_state_t         state;
  logic [ADDR_W-1:0] addr, addr_nx, ld_addr, off;
  logic              we_r, wid_r, beat;
  logic [DATA_W-1:0] wdat, rd;
  logic [3:0]        cnt;
  logic              ram_we;

  assign addr_nx = addr + 16'd1;

  // Address the RAM port looks at: the one about to be read into dbo on
  // entry to BEAT, or the current address while a write beat is in flight.
  always_comb begin
    ld_addr = addr;
    if (state == IDLE)                ld_addr = abi;
    else if (state == BEAT && !we_r)  ld_addr = addr_nx;
    off = ld_addr - BASE;
  end

  assign ram_we = rst && (state == BEAT) && we_r;

  mem_responder_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk (clk),
    .we  (ram_we),
    .a   (off[AW-1:0]),
    .wd  (wdat),
    .rd  (rd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
      we_r  <= 1'b0;
      wid_r <= 1'b0;
      beat  <= 1'b0;
      wdat  <= '0;
      cnt   <= '0;
      dbo   <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr  <= abi;
          we_r  <= we;
          wid_r <= wid;
          wdat  <= dbi;
          beat  <= 1'b0;
          if (in_win(abi, BASE, 32'(DEPTH))) begin
            if (WAIT > 0) begin
              state <= mem_responder_pkg::WAIT;
              cnt   <= 4'(WAIT - 1);
            end else begin
              state <= BEAT;
              if (!we) dbo <= rd;
            end
          end else begin
            state <= ERR;
          end
        end
        mem_responder_pkg::WAIT: begin
          if (cnt == 4'd0) begin
            state <= BEAT;
            if (!we_r) dbo <= rd;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        BEAT: begin
          if (!wid_r || beat) begin
            state <= IDLE;
          end else begin
            // Second beat: high write byte is whatever is on dbi now.
            addr <= addr_nx;
            beat <= 1'b1;
            wdat <= dbi;
            if (in_win(addr_nx, BASE, 32'(DEPTH))) begin
              if (WAIT > 0) begin
                state <= mem_responder_pkg::WAIT;
                cnt   <= 4'(WAIT - 1);
              end else begin
                state <= BEAT;
                if (!we_r) dbo <= rd;
              end
            end else begin
              state <= ERR;
            end
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rdy  = (state == BEAT);
  assign err  = (state == ERR);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (WAIT=2 and WAIT=0) driven by directed and
// random transactions, checked cycle by cycle against a transaction-level
// model (expected pulse cycles from the timing rules, byte array for RAM).
module tb_mem_responder;

  localparam int TB_BASE  = 0;
  localparam int TB_DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] abi [2];
  logic [7:0]  dbi [2];
  logic        req [2], we [2], wid [2];
  logic [7:0]  dbo [2];
  logic        rdy [2], err [2], busy [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] mm [2][256];
  logic [7:0] last_dbo [2];

  mem_responder #(.BASE(16'h0000), .DEPTH(256), .WAIT(2)) u0 (
    .clk(clk), .rst(rst), .abi(abi[0]), .dbi(dbi[0]), .req(req[0]),
    .we(we[0]), .wid(wid[0]), .dbo(dbo[0]), .rdy(rdy[0]), .err(err[0]),
    .busy(busy[0]));

  mem_responder #(.BASE(16'h0000), .DEPTH(256), .WAIT(0)) u1 (
    .clk(clk), .rst(rst), .abi(abi[1]), .dbi(dbi[1]), .req(req[1]),
    .we(we[1]), .wid(wid[1]), .dbo(dbo[1]), .rdy(rdy[1]), .err(err[1]),
    .busy(busy[1]));

  task automatic chk(input string tag, input int s, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d: got %0h expected %0h", tag, s, obs, exp);
    end
  endtask

  function automatic bit inwin(input logic [15:0] a);
    int d;
    d = int'(a) - TB_BASE;
    return (d >= 0) && (d < TB_DEPTH);
  endfunction

  function automatic int idx(input logic [15:0] a);
    return int'(a) - TB_BASE;
  endfunction

  task automatic chk_out(input string tag, input int s, input logic er,
                         input logic ee, input logic eb);
    chk({tag, ".rdy"},  s, 16'(rdy[s]),  16'(er));
    chk({tag, ".err"},  s, 16'(err[s]),  16'(ee));
    chk({tag, ".busy"}, s, 16'(busy[s]), 16'(eb));
    chk({tag, ".dbo"},  s, 16'(dbo[s]),  16'(last_dbo[s]));
  endtask

  // One transaction, entered and left in an idle cycle 1 ns after an edge.
  task automatic txn(input int s, input logic [15:0] a, input logic w,
                     input logic wd, input logic [7:0] d0, input logic [7:0] d1,
                     input bit pulse);
    int W, b1, b2, ec, endc;
    logic [15:0] a2;
    W  = (s == 0) ? 2 : 0;
    b1 = -1; b2 = -1; ec = -1;
    a2 = a + 16'd1;
    if (!inwin(a)) begin
      ec = 1; endc = 1;
    end else begin
      b1 = 1 + W; endc = b1;
      if (wd) begin
        if (inwin(a2)) begin b2 = 2 + 2 * W; endc = b2; end
        else begin ec = 2 + W; endc = ec; end
      end
    end
    abi[s] = a; we[s] = w; wid[s] = wd; dbi[s] = d0; req[s] = 1'b1;
    for (int c = 1; c <= endc + 1; c++) begin
      @(posedge clk); #1;
      if (!w && c == b1) last_dbo[s] = mm[s][idx(a)];
      if (!w && c == b2) last_dbo[s] = mm[s][idx(a2)];
      chk_out("txn", s, (c == b1) || (c == b2), c == ec, c <= endc);
      if (w && c == b1) mm[s][idx(a)]  = d0;
      if (w && c == b2) mm[s][idx(a2)] = d1;
      req[s] = 1'b0;
      abi[s] = 16'($urandom);
      dbi[s] = 8'($urandom);
      we[s]  = 1'($urandom);
      wid[s] = 1'($urandom);
      if (pulse && c <= endc) req[s] = 1'($urandom_range(0, 1));
      if (c == b1) dbi[s] = d1;
    end
  endtask

  initial begin
    logic [15:0] ra;
    int s;
    // Reset asserted together with a request: reset must win.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      abi[i] = 16'h0010; dbi[i] = 8'hFF; req[i] = 1'b1; we[i] = 1'b1;
      wid[i] = 1'b0; last_dbo[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk_out("reset", i, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) chk_out("idle", i, 1'b0, 1'b0, 1'b0);

    // Give every RAM byte a known value.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++)
        txn(i, 16'(j), 1'b1, 1'b0, 8'($urandom), 8'h00, 1'b0);

    // Directed steps on the WAIT=2 instance.
    txn(0, 16'h0010, 1'b1, 1'b0, 8'h64, 8'h00, 1'b0);
    txn(0, 16'h0010, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    txn(0, 16'h0020, 1'b1, 1'b1, 8'h40, 8'h20, 1'b0);
    txn(0, 16'h0020, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    txn(0, 16'h7A0E, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    txn(0, 16'h00FF, 1'b1, 1'b1, 8'h5A, 8'hA5, 1'b0);
    txn(0, 16'h00FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    txn(0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    txn(0, 16'hFFFF, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    txn(0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    txn(0, 16'h0041, 1'b1, 1'b1, 8'hC3, 8'h3C, 1'b1);
    txn(0, 16'h0041, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);

    // Reset during the wait states of a write.
    abi[0] = 16'h0030; we[0] = 1'b1; wid[0] = 1'b0;
    dbi[0] = ~mm[0][16'h0030]; req[0] = 1'b1;
    @(posedge clk); #1;
    chk_out("rstw.c1", 0, 1'b0, 1'b0, 1'b1);
    req[0] = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    last_dbo[0] = 8'h00; last_dbo[1] = 8'h00;
    chk_out("rstw.c2", 0, 1'b0, 1'b0, 1'b0);
    chk_out("rstw.c2", 1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk_out("rstw.after", 0, 1'b0, 1'b0, 1'b0);
    end
    txn(0, 16'h0030, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Zero-wait instance.
    txn(1, 16'h0010, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    txn(1, 16'h0020, 1'b1, 1'b1, 8'h40, 8'h20, 1'b0);
    txn(1, 16'h0020, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    txn(1, 16'h00FF, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    txn(1, 16'h7A0E, 1'b1, 1'b1, 8'h77, 8'h88, 1'b0);

    // Random traffic, mostly inside the window.
    repeat (200) begin
      s = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       ra = 16'($urandom);
        1:       ra = 16'h00FF;
        default: ra = 16'($urandom_range(0, 255));
      endcase
      txn(s, ra, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's 16-bit address / 8-bit data bus. It accepts byte or little-endian 16-bit read/write requests whose addresses come from the address generation unit, and inserts a parameterised number of wait states. It services the requests from a local RAM window, completing each beat with a one-cycle ready pulse. Out-of-window accesses are answered with an error pulse instead of a transfer.

## Interface
- `BASE`, default 16'h0000: first address of the RAM window.
- `DEPTH`, default 256: window size in bytes, 1..65536.
- `WAIT`, default 2: wait-state cycles inserted before each beat, 0..15.

- `clk`  in  1: sole clock, all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `abi`  in  16: request address.
- `dbi`  in  8: write data.
- `req`  in  1: request strobe, sampled only when `busy`=0.
- `we`  in  1: 1 = write, 0 = read; sampled with `req`.
- `wid`  in  1: 1 = two-byte transfer at `abi`, `abi`+1; sampled with `req`.
- `dbo`  out  8: read data, valid while `rdy`=1 on a read beat.
- `rdy`  out  1: one-cycle beat-complete pulse.
- `err`  out  1: one-cycle out-of-window pulse.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `busy`=0. On `req`=1, latch `abi`, `we`, `wid` and `dbi`, and clear the beat index.
    - Address in window: go to WAIT if `WAIT`>0, else to BEAT.
    - Address out of window: go to ERR.
  - WAIT: the counter loads `WAIT`-1 on entry and decrements each cycle. At 0, go to BEAT.
  - BEAT: `rdy`=1 for this cycle.
    - Write: `mem[addr-BASE]` is written at the end of the cycle.
    - Read: `dbo` = `mem[addr-BASE]`, registered on entry to BEAT.
    - Single beat, or second beat: go to IDLE.
    - First beat of a wide transfer: `addr` increments modulo 2^16 (16'hFFFF -> 16'h0000), then re-check the window. In window: go to WAIT, or to BEAT if `WAIT`=0. Out of window: go to ERR.
  - ERR: `err`=1 for one cycle, no memory access, go to IDLE.
- Window check: `(addr - BASE)` computed in 17 bits; in window iff 0 <= diff < `DEPTH`.
- Wide write data:
  - Low byte is `dbi` at acceptance.
  - High byte is `dbi` sampled in the first-beat `rdy` cycle.
- Wide read: first `rdy` carries the low byte, second carries the high byte.
- `req` while `busy`=1 is ignored; there is no queueing.
- `dbo` holds its last read value until the next read beat.
- Reset mid-transfer aborts it. A wide write aborted after beat 1 keeps the low byte written.
- RAM contents are not cleared by reset.

## Timing
- Reset values (`rst`=0 at an edge): state IDLE, `rdy`=0, `err`=0, `busy`=0, `dbo`=8'h00. Reset wins over a simultaneous `req`.
- Cycle numbering: `req` is sampled in cycle 0.
  - `busy` rises in cycle 1.
  - First `rdy` is in cycle 1+`WAIT`.
  - Second `rdy` (wide) is in cycle 2+2·`WAIT`.
  - `err` for a bad first address is in cycle 1.
- `busy` falls in the cycle after the final `rdy`/`err`. A new `req` is accepted in that cycle at the earliest.
- `rdy` and `err` are never high together.

## Structure
- Package `mem_responder_pkg`:
  - state enum `mr_state_t` {IDLE, WAIT, BEAT, ERR};
  - default parameter constants;
  - `ADDR_W`=16 and `DATA_W`=8.
- Sub-module `mem_responder_ram`: `DEPTH`×8 single-port RAM, synchronous write, asynchronous read. The FSM, address register and window check stay in the top module.

## Test plan
- `WAIT`=2: write 8'h64 to 16'h0010 -> `busy` in cycles 1-3, `rdy` in cycle 3. Read 16'h0010 -> `rdy` with `dbo`=8'h64.
- Wide write to 16'h0020: low 8'h40, high 8'h20 presented on the first `rdy`. Then wide read -> `rdy` in cycles 3 and 6, `dbo`=8'h40 then 8'h20.
- Read of 16'h7A0E (`BASE`=0, `DEPTH`=256) -> `err` in cycle 1, no `rdy`, `dbo` unchanged, RAM unchanged.
- Wide write at 16'h00FF -> `rdy` in cycle 3 with the byte written. Then `err` in cycle 4 (16'h0100 is out of window), no second `rdy`.
- `req` pulsed during WAIT -> ignored. `rst`=0 during WAIT of a write -> all outputs at reset values next cycle, no `rdy`, target byte unchanged.
- `WAIT`=0 build: byte read -> `rdy` in cycle 1. Wide read -> `rdy` in cycles 1 and 2.
